// File: rtl/vmem_arbiter.sv
// vmem_arbiter: single-port data-memory arbiter shared by the scalar LSU and
// the vector memory access unit (VMA). A pending vector instruction gets a
// one-cycle v_start only while the port is free. The port is then locked to
// the VMA for the whole burst. Scalar accesses are time-multiplexed in IDLE.
// A watchdog aborts bursts that run too long, and a fairness flag gives a
// waiting scalar access the first slot after each burst.
//
// Ports:
//   clk, rst                         clock, async active-low reset
//   s_req/s_we/s_addr/s_wdata        scalar request (held until s_ready)
//   s_ready                          scalar granted this cycle (combinational)
//   s_rvalid/s_rdata                 registered scalar read return
//   v_req / v_start                  vector instruction pending / start pulse
//   v_busy/v_done                    VMA status
//   v_read_en/v_write_en/v_addr/v_wdata  VMA memory request
//   v_rdata                          memory read data to VMA (= m_rdata)
//   m_re/m_we/m_addr/m_wdata/m_rdata data memory port (combinational read)
//   err                              sticky watchdog-abort flag
module vmem_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_ready,
  output logic        s_rvalid,
  output logic [31:0] s_rdata,
  input  logic        v_req,
  output logic        v_start,
  input  logic        v_busy,
  input  logic        v_done,
  input  logic        v_read_en,
  input  logic        v_write_en,
  input  logic [31:0] v_addr,
  input  logic [31:0] v_wdata,
  output logic [31:0] v_rdata,
  output logic        m_re,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, VSTART, VLOCK, VREL} state_t;

  localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT);

  state_t        state;
  logic          owed;
  logic [TW-1:0] wdog;
  logic          vec_go_c;
  logic          s_grant_c;

  // A vector start wins over a scalar request unless the scalar side is owed a slot
  assign vec_go_c  = (state == IDLE) && v_req && !(s_req && owed);
  assign s_grant_c = (state == IDLE) && s_req && !vec_go_c;

  assign s_ready = s_grant_c;
  assign v_start = (state == VSTART);
  assign v_rdata = m_rdata;

  // Memory port mux: scalar on grant in IDLE, VMA during VLOCK/VREL, idle otherwise
  always_comb begin
    m_re    = 1'b0;
    m_we    = 1'b0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (s_grant_c) begin
          m_re    = !s_we;
          m_we    = s_we;
          m_addr  = s_addr;
          m_wdata = s_wdata;
        end
      end
      VLOCK, VREL: begin
        m_re    = v_read_en;
        m_we    = v_write_en;
        m_addr  = v_addr;
        m_wdata = v_wdata;
      end
      default: ;
    endcase
  end

  // Sequencer, fairness flag, watchdog and scalar read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owed     <= 1'b0;
      wdog     <= '0;
      err      <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
    end else begin
      s_rvalid <= s_grant_c && !s_we;
      if (s_grant_c && !s_we) s_rdata <= m_rdata;

      case (state)
        IDLE: begin
          if (s_grant_c) owed  <= 1'b0;
          if (vec_go_c)  state <= VSTART;
        end
        VSTART: begin
          wdog  <= '0;
          state <= VLOCK;
        end
        VLOCK: begin
          if (wdog != TIMEOUT_W) wdog <= wdog + TW'(1);
          if (v_done) begin
            state <= VREL;
          end else if (!v_busy) begin
            // VMA decoded a NOP or finished without a done pulse
            state <= IDLE;
          end else if (wdog == TIMEOUT_W) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        VREL: begin
          if (s_req) owed <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
module tb_vmem_arbiter;

  localparam int unsigned TO = 8;
  localparam int unsigned TWB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready, s_rvalid;
  logic [31:0] s_rdata;
  logic        v_req, v_start, v_busy, v_done, v_read_en, v_write_en;
  logic [31:0] v_addr, v_wdata, v_rdata;
  logic        m_re, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        err;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int errors = 0;

  vmem_arbiter #(.TIMEOUT(TO), .TW(TWB)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .v_req(v_req), .v_start(v_start), .v_busy(v_busy), .v_done(v_done),
    .v_read_en(v_read_en), .v_write_en(v_write_en), .v_addr(v_addr),
    .v_wdata(v_wdata), .v_rdata(v_rdata),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // Word-addressed memory with combinational read, written on the rising edge
  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) if (m_we) mem[m_addr[9:2]] <= m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] widx(input logic [31:0] a);
    return a[9:2];
  endfunction

  // One scalar access in IDLE: granted the same cycle, read returns next cycle
  task automatic scalar_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = wd; v_req = 1'b0;
    #1;
    chk("s_ready_grant", s_ready, 1'b1);
    chk("s_m_re", m_re, !we);
    chk("s_m_we", m_we, we);
    chk("s_m_addr", m_addr, addr);
    if (we) ref_mem[widx(addr)] = wd;
    @(negedge clk);
    s_req = 1'b0;
    chk("s_rvalid", s_rvalid, !we);
    if (!we) chk("s_rdata", s_rdata, ref_mem[widx(addr)]);
  endtask

  // Vector burst of n beats; returns during the release cycle
  task automatic vec_burst(input int n, input logic we, input logic [31:0] base, input logic hold_s);
    logic [31:0] a;
    @(negedge clk);
    v_req = 1'b1; s_req = hold_s; s_we = 1'b0;
    #1;
    chk("v_idle_s_ready", s_ready, 1'b0);
    chk("v_idle_v_start", v_start, 1'b0);
    @(negedge clk);
    v_req = 1'b0; v_read_en = 1'b1; v_addr = 32'h0000_03F0;
    #1;
    chk("vstart_pulse", v_start, 1'b1);
    chk("vstart_m_re", m_re, 1'b0);
    chk("vstart_m_we", m_we, 1'b0);
    chk("vstart_m_addr", m_addr, 32'h0);
    chk("vstart_s_ready", s_ready, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = base + 32'(4 * i);
      v_busy = 1'b1; v_read_en = !we; v_write_en = we; v_addr = a;
      v_wdata = $urandom; v_done = (i == n - 1);
      #1;
      chk("beat_m_re", m_re, !we);
      chk("beat_m_we", m_we, we);
      chk("beat_m_addr", m_addr, a);
      chk("beat_s_ready", s_ready, 1'b0);
      chk("beat_v_start", v_start, 1'b0);
      if (!we) chk("beat_v_rdata", v_rdata, ref_mem[widx(a)]);
      else ref_mem[widx(a)] = v_wdata;
    end
    @(negedge clk);
    v_done = 1'b0; v_busy = 1'b0; v_read_en = 1'b0; v_write_en = 1'b0;
    #1;
    chk("vrel_s_ready", s_ready, 1'b0);
    chk("vrel_m_re", m_re, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b0;
    s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
    v_req = 0; v_busy = 0; v_done = 0; v_read_en = 0; v_write_en = 0;
    v_addr = 0; v_wdata = 0;
    #12;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_s_rvalid", s_rvalid, 1'b0);
    chk("rst_s_rdata", s_rdata, 32'h0);
    chk("rst_v_start", v_start, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Directed scalar read of 0x100, then a 4-beat vector load
    scalar_op(1'b0, 32'h100, 32'h0);
    vec_burst(4, 1'b0, 32'h200, 1'b0);

    // Random mix of scalar accesses and vector bursts
    for (int k = 0; k < 24; k++) begin
      logic [31:0] ra;
      ra = {22'h0, 8'($urandom), 2'b00};
      case ($urandom_range(0, 2))
        0: scalar_op(1'b0, ra, 32'h0);
        1: scalar_op(1'b1, ra, $urandom);
        default: vec_burst($urandom_range(1, 6), 1'($urandom), {22'h0, 8'($urandom_range(0, 200)), 2'b00}, 1'b0);
      endcase
    end

    // Fairness: scalar held through a burst is owed the first slot afterwards
    s_addr = 32'h40;
    vec_burst(3, 1'b1, 32'h300, 1'b1);
    @(negedge clk);
    v_req = 1'b1;
    #1;
    chk("fair_s_ready", s_ready, 1'b1);
    chk("fair_m_re", m_re, 1'b1);
    chk("fair_m_addr", m_addr, 32'h40);
    chk("fair_v_start", v_start, 1'b0);
    @(negedge clk);
    s_req = 1'b0;
    chk("fair_rvalid", s_rvalid, 1'b1);
    chk("fair_rdata", s_rdata, ref_mem[widx(32'h40)]);
    chk("fair_wait_v_start", v_start, 1'b0);
    @(negedge clk);
    v_req = 1'b0;
    chk("fair_v_start_late", v_start, 1'b1);

    // That start is a NOP: VMA never goes busy, lock releases after one cycle
    @(negedge clk);
    v_busy = 1'b0; v_read_en = 1'b0;
    @(negedge clk);
    chk("nop_err", err, 1'b0);
    chk("nop_v_start", v_start, 1'b0);
    scalar_op(1'b0, 32'h44, 32'h0);

    // Watchdog: VMA busy forever, lock lasts TO+1 cycles then aborts
    @(negedge clk);
    v_req = 1'b1;
    @(negedge clk);
    v_req = 1'b0;
    chk("wd_v_start", v_start, 1'b1);
    for (int c = 0; c < int'(TO) + 1; c++) begin
      @(negedge clk);
      v_busy = 1'b1; v_read_en = 1'b1; v_addr = {22'h0, 8'($urandom), 2'b00};
      s_req = 1'b1; s_we = 1'b0; s_addr = 32'h80;
      #1;
      chk("wd_lock_s_ready", s_ready, 1'b0);
      chk("wd_lock_m_re", m_re, 1'b1);
      chk("wd_lock_err", err, 1'b0);
    end
    @(negedge clk);
    v_read_en = 1'b0;
    #1;
    chk("wd_err", err, 1'b1);
    chk("wd_s_resume", s_ready, 1'b1);
    chk("wd_s_addr", m_addr, 32'h80);
    @(negedge clk);
    s_req = 1'b0; v_busy = 1'b0;
    chk("wd_rdata", s_rdata, ref_mem[widx(32'h80)]);
    chk("wd_err_sticky", err, 1'b1);

    // Reset in the middle of a locked burst
    @(negedge clk);
    v_req = 1'b1;
    @(negedge clk);
    v_req = 1'b0;
    @(negedge clk);
    v_busy = 1'b1; v_read_en = 1'b1; v_addr = 32'h10;
    #1;
    chk("mid_lock_m_re", m_re, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_m_re", m_re, 1'b0);
    chk("mid_rst_v_start", v_start, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_s_rdata", s_rdata, 32'h0);
    chk("mid_rst_s_rvalid", s_rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b1; v_busy = 1'b0; v_read_en = 1'b0;
    scalar_op(1'b0, 32'h100, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
